scrambler_frame_ctrl: RTL

Frame sequencer placed in front of the scrambler. It accepts AXI-Stream frames and reseeds the scrambler through a seed-load handshake before each frame. It then passes the frame through to the scrambler. It also enforces a maximum frame length and keeps frame and error statistics for the control plane.

---
 rtl/scrambler_frame_ctrl_if.sv | 12 +
 rtl/scrambler_frame_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/scrambler_frame_ctrl_if.sv
// AXI-Stream beat bundle used on both sides of the scrambler frame sequencer.
interface scrambler_frame_ctrl_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer ahead of the scrambler: reseeds via a seed handshake before
// each frame, passes beats through, caps frame length and keeps statistics.
module scrambler_frame_ctrl #(
  parameter int                    WIDTH         = 24,
  parameter int                    SEED_WIDTH    = 7,
  parameter logic [SEED_WIDTH-1:0] SEED_INIT     = 7'b1011101,
  parameter int                    SETTLE_CYCLES = 2,
  parameter int                    MAX_BEATS     = 256
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  scrambler_frame_ctrl_if.slave  s_axis,
  scrambler_frame_ctrl_if.master m_axis,
  output logic [SEED_WIDTH-1:0]  seed_data,
  output logic                   seed_valid,
  input  logic                   seed_ready,
  input  logic                   cfg_seed_auto,
  input  logic                   cfg_seed_wr,
  input  logic [SEED_WIDTH-1:0]  cfg_seed,
  output logic [15:0]            stat_frames,
  output logic                   stat_overlength,
  output logic                   busy
);
  localparam int BW = $clog2(MAX_BEATS);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [BW-1:0]         LAST_BEAT   = BW'(MAX_BEATS - 1);
  localparam logic [SW-1:0]         SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [SEED_WIDTH-1:0] SEED_ONE    = SEED_WIDTH'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SETTLE, ST_PASS, ST_DROP} state_t;

  state_t                  state_reg, state_next;
  logic [SW-1:0]           settle_reg, settle_next;
  logic [BW-1:0]           beat_reg;
  logic [SEED_WIDTH-1:0]   seed_reg;
  logic [SEED_WIDTH-1:0]   seed_plus;
  logic [SEED_WIDTH-1:0]   seed_inc;
  logic [SEED_WIDTH-1:0]   cfg_val;
  logic                    seed_hs;
  logic                    beat_hs;
  logic                    frame_done;
  logic                    overlen;

  // The LFSR must never be seeded with zero, so zero is mapped to one.
  assign seed_plus = seed_reg + 1'b1;
  assign seed_inc  = (seed_plus == '0) ? SEED_ONE : seed_plus;
  assign cfg_val   = (cfg_seed == '0) ? SEED_ONE : cfg_seed;
  assign seed_data = seed_reg;
  assign busy      = (state_reg != ST_IDLE);

  always_comb begin
    state_next      = state_reg;
    settle_next     = settle_reg;
    seed_valid      = 1'b0;
    s_axis.tready   = 1'b0;
    m_axis.tvalid   = 1'b0;
    m_axis.tlast    = 1'b0;
    m_axis.tdata    = '0;
    seed_hs         = 1'b0;
    beat_hs         = 1'b0;
    frame_done      = 1'b0;
    overlen         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (s_axis.tvalid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        seed_valid = 1'b1;
        if (seed_ready) begin
          seed_hs     = 1'b1;
          settle_next = SETTLE_LOAD;
          state_next  = (SETTLE_CYCLES == 0) ? ST_PASS : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_reg == '0) state_next = ST_PASS;
        else                  settle_next = settle_reg - 1'b1;
      end
      ST_PASS: begin
        m_axis.tdata  = s_axis.tdata;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tlast  = s_axis.tvalid & (s_axis.tlast | (beat_reg == LAST_BEAT));
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready) begin
          beat_hs = 1'b1;
          if (s_axis.tlast) begin
            frame_done = 1'b1;
            state_next = ST_IDLE;
          end else if (beat_reg == LAST_BEAT) begin
            frame_done = 1'b1;
            overlen    = 1'b1;
            state_next = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg  <= ST_IDLE;
      settle_reg <= '0;
      beat_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      if (state_reg != ST_PASS) beat_reg <= '0;
      else if (beat_hs)         beat_reg <= beat_reg + 1'b1;
    end
  end

  // A configuration write overrides a same-cycle auto-advance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                     seed_reg <= SEED_INIT;
    else if (cfg_seed_wr)             seed_reg <= cfg_val;
    else if (seed_hs && cfg_seed_auto) seed_reg <= seed_inc;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_frames     <= '0;
      stat_overlength <= 1'b0;
    end else begin
      if (frame_done) stat_frames <= stat_frames + 16'd1;
      if (overlen)    stat_overlength <= 1'b1;
    end
  end
endmodule
